// File: rtl/pet_vitals_engine_pkg.sv
// Shared opcodes and life-state encoding for the pet vitals engine.
package pet_pkg;
   localparam logic [3:0] OP_ADD    = 4'h1;
   localparam logic [3:0] OP_SLEEP  = 4'h2;
   localparam logic [3:0] OP_WAKE   = 4'h3;
   localparam logic [3:0] OP_REVIVE = 4'hF;

   typedef enum logic [1:0] {
      ST_AWAKE = 2'd0,
      ST_SLEEP = 2'd1,
      ST_DECAY = 2'd2,
      ST_DEAD  = 2'd3
   } pet_state_t;
endpackage

// File: rtl/pet_vitals_engine_if.sv
// Care-command valid/ready channel between the command decoder and the vitals engine.
interface pet_cmd_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd_code;

   modport master (output cmd_valid, output cmd_code, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_code, output cmd_ready);
endinterface

// File: rtl/pet_vitals_engine_prescaler.sv
// Free-running tick prescaler: one-cycle registered pulse while the count sits at TICK_DIV-1.
module pet_tick_prescaler #(
   parameter int unsigned TICK_DIV = 10_000_000
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);
   localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] count;
   logic [CW-1:0] count_next;

   always_comb begin
      count_next = (count == LAST) ? '0 : count + CW'(1);
   end

   // The pulse is registered from the next count so it coincides with count == LAST.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
         tick  <= 1'b0;
      end else begin
         count <= count_next;
         tick  <= (count_next == LAST);
      end
   end
endmodule

// File: rtl/pet_vitals_engine.sv
// Pet vitals engine: saturating vitals, per-tick randomised decay pass, care commands and life state.
module pet_vitals_engine
   import pet_pkg::*;
#(
   parameter int unsigned NUM_STATS  = 6,
   parameter int unsigned STAT_W     = 5,
   parameter int unsigned TICK_DIV   = 10_000_000,
   parameter int unsigned CMD_STEP   = 4,
   parameter int unsigned ENERGY_IDX = 4,
   parameter int unsigned HEALTH_IDX = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [7:0]                    rand_in,
   pet_cmd_if.slave                      cmd,
   output logic [NUM_STATS*STAT_W-1:0]   stats_flat,
   output logic                          is_sleeping,
   output logic                          alive,
   output logic                          second,
   output logic                          cmd_err
);
   localparam logic [STAT_W-1:0] STAT_MAX = '1;
   localparam logic [STAT_W-1:0] STEP     = STAT_W'(CMD_STEP);
   localparam logic [3:0]        LAST_IDX = 4'(NUM_STATS - 1);
   localparam logic [4:0]        N_STATS  = 5'(NUM_STATS);
   localparam logic [3:0]        ENERGY_I = 4'(ENERGY_IDX);
   localparam logic [3:0]        HEALTH_I = 4'(HEALTH_IDX);

   if (TICK_DIV < NUM_STATS + 2) begin : g_bad_tick_div
      $error("pet_vitals_engine: TICK_DIV must be >= NUM_STATS+2");
   end

   pet_state_t        state, state_next, ret_state, ret_next, post;
   logic [3:0]        idx, idx_next;
   logic [STAT_W-1:0] vitals [NUM_STATS];

   logic              wr_en, fill_max, err_next, cmd_fire;
   logic [3:0]        unit_idx, cidx, opcode;
   logic              unit_inc;
   logic [STAT_W-1:0] unit_amt, unit_in, unit_out;
   logic [STAT_W:0]   unit_sum;
   logic [STAT_W-1:0] health_after, energy_after;

   pet_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .tick  (second)
   );

   assign cmd.cmd_ready = (state != ST_DECAY);
   assign cmd_fire      = cmd.cmd_valid & cmd.cmd_ready;
   assign opcode        = cmd.cmd_code[7:4];
   assign cidx          = cmd.cmd_code[3:0];
   assign is_sleeping   = (state == ST_SLEEP);
   assign alive         = (state != ST_DEAD);

   // Single saturating add/sub unit shared by the decay pass and the ADD command.
   always_comb begin
      unit_in = '0;
      for (int unsigned i = 0; i < NUM_STATS; i++) begin
         if (unit_idx == 4'(i)) unit_in = vitals[i];
      end
      unit_sum = {1'b0, unit_in} + {1'b0, unit_amt};
      if (unit_inc) unit_out = unit_sum[STAT_W] ? STAT_MAX : unit_sum[STAT_W-1:0];
      else          unit_out = (unit_in < unit_amt) ? '0 : unit_in - unit_amt;
   end

   // End-of-pass decisions must see the vital written in this same final cycle.
   assign health_after = (HEALTH_I == LAST_IDX) ? unit_out : vitals[HEALTH_IDX];
   assign energy_after = (ENERGY_I == LAST_IDX) ? unit_out : vitals[ENERGY_IDX];

   always_comb begin
      state_next = state;
      ret_next   = ret_state;
      idx_next   = idx;
      post       = state;
      err_next   = 1'b0;
      wr_en      = 1'b0;
      fill_max   = 1'b0;
      unit_idx   = idx;
      unit_inc   = 1'b0;
      unit_amt   = '0;

      if (state == ST_DECAY) begin
         wr_en = 1'b1;
         if (ret_state == ST_SLEEP && idx == ENERGY_I) begin
            unit_inc = 1'b1;
            unit_amt = STAT_W'(1);
         end else begin
            unit_amt = STAT_W'(rand_in[idx[2:0]]);
         end
         if (idx == LAST_IDX) begin
            if (health_after == '0)
               state_next = ST_DEAD;
            else if (ret_state == ST_SLEEP && energy_after == STAT_MAX)
               state_next = ST_AWAKE;
            else
               state_next = ret_state;
         end else begin
            idx_next = idx + 4'd1;
         end
      end else begin
         if (cmd_fire) begin
            unit_idx = cidx;
            unit_inc = 1'b1;
            unit_amt = STEP;
            case (state)
               ST_AWAKE: begin
                  case (opcode)
                     OP_ADD:   if ({1'b0, cidx} < N_STATS) wr_en = 1'b1; else err_next = 1'b1;
                     OP_SLEEP: post = ST_SLEEP;
                     OP_WAKE:  post = ST_AWAKE;
                     default:  err_next = 1'b1;
                  endcase
               end
               ST_SLEEP: begin
                  case (opcode)
                     OP_SLEEP: post = ST_SLEEP;
                     OP_WAKE:  post = ST_AWAKE;
                     default:  err_next = 1'b1;
                  endcase
               end
               default: begin
                  if (opcode == OP_REVIVE) begin
                     fill_max = 1'b1;
                     post     = ST_AWAKE;
                  end else begin
                     err_next = 1'b1;
                  end
               end
            endcase
         end
         if (second && state != ST_DEAD) begin
            state_next = ST_DECAY;
            ret_next   = post;
            idx_next   = '0;
         end else begin
            state_next = post;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_AWAKE;
         ret_state <= ST_AWAKE;
         idx       <= '0;
         cmd_err   <= 1'b0;
         for (int unsigned i = 0; i < NUM_STATS; i++) vitals[i] <= STAT_MAX;
      end else begin
         state     <= state_next;
         ret_state <= ret_next;
         idx       <= idx_next;
         cmd_err   <= err_next;
         for (int unsigned i = 0; i < NUM_STATS; i++) begin
            if (fill_max)
               vitals[i] <= STAT_MAX;
            else if (wr_en && unit_idx == 4'(i))
               vitals[i] <= unit_out;
         end
      end
   end

   always_comb begin
      stats_flat = '0;
      for (int unsigned i = 0; i < NUM_STATS; i++) begin
         stats_flat[i*STAT_W +: STAT_W] = vitals[i];
      end
   end
endmodule
